// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

   // Ownership phases of the shared transmitter
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } arb_state_t;

   // Bits needed to index n items (at least one bit)
   function automatic int unsigned idx_width(input int unsigned n);
      if (n > 1) return $unsigned($clog2(n));
      return 1;
   endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module uart_rr_pick
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               vld_c,
   output logic [IDX_W-1:0]   idx_c
);

   int unsigned cand;

   // Scan from the pointer upward, taking the first active request
   always_comb begin
      vld_c = 1'b0;
      idx_c = '0;
      cand  = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = 32'(ptr) + i;
         if (cand >= NUM_REQ) cand = cand - NUM_REQ;
         if (!vld_c && req[IDX_W'(cand)]) begin
            vld_c = 1'b1;
            idx_c = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of a single UART transmitter shared by NUM_REQ clients.
// Optional start timeout enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned START_TIMEOUT = 64
) (
   input  logic                           Clk,
   input  logic                           Rst_n,
   input  logic [NUM_REQ-1:0]             Req,
   input  logic [NUM_REQ*DATA_BITS-1:0]   Req_Data,
   input  logic                           CTS,
   input  logic                           Tx_Busy,
   output logic [DATA_BITS-1:0]           Tx_Data,
   output logic                           Transmit_Start,
   output logic [NUM_REQ-1:0]             Gnt,
   output logic [NUM_REQ-1:0]             Done,
   output logic                           Active,
   output logic                           Timeout_Err
);

   localparam int unsigned IDX_W = idx_width(NUM_REQ);

   if (NUM_REQ < 2 || START_TIMEOUT < 1) begin : g_bad_cfg
      $error("uart_tx_arbiter: NUM_REQ must be >= 2 and START_TIMEOUT >= 1");
   end

   arb_state_t           state_q, state_d;
   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 start_q, start_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic                 active_q, active_d;

   logic                 win_vld;
   logic [IDX_W-1:0]     win_idx;
   logic [DATA_BITS-1:0] win_data;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = idx_width(START_TIMEOUT);
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 terr_q, terr_d;
`endif

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req   (Req),
      .ptr   (ptr_q),
      .vld_c (win_vld),
      .idx_c (win_idx)
   );

   // Select the winning client's payload
   always_comb begin
      win_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_idx == IDX_W'(i)) win_data = Req_Data[i*DATA_BITS +: DATA_BITS];
      end
   end

   // Next-state and registered-output decisions
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      data_d  = data_q;
      start_d = start_q;
      gnt_d   = '0;
      done_d  = '0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_d   = cnt_q;
      terr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (CTS && !Tx_Busy && win_vld) begin
               data_d  = win_data;
               owner_d = win_idx;
               gnt_d   = NUM_REQ'(1) << win_idx;
               ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
               start_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
               cnt_d   = '0;
`endif
               state_d = START;
            end
         end
         START: begin
            if (Tx_Busy) begin
               start_d = 1'b0;
               state_d = BUSY;
            end
`ifdef UART_ARB_TIMEOUT_EN
            else if (start_q && cnt_q == CNT_W'(START_TIMEOUT - 1)) begin
               // transmitter never answered: release the channel
               start_d = 1'b0;
               terr_d  = 1'b1;
               state_d = IDLE;
            end
            else begin
               start_d = 1'b1;
               if (start_q) cnt_d = cnt_q + CNT_W'(1);
            end
`else
            else begin
               start_d = 1'b1;
            end
`endif
         end
         BUSY: begin
            if (!Tx_Busy) begin
               done_d  = NUM_REQ'(1) << owner_q;
               state_d = IDLE;
            end
         end
         default: begin
            start_d = 1'b0;
            state_d = IDLE;
         end
      endcase
      active_d = (state_d != IDLE);
   end

   // State and output registers
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         owner_q  <= '0;
         data_q   <= '0;
         start_q  <= 1'b0;
         gnt_q    <= '0;
         done_q   <= '0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         data_q   <= data_d;
         start_q  <= start_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         active_q <= active_d;
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   // Start-timeout counter and error pulse
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         cnt_q  <= '0;
         terr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         terr_q <= terr_d;
      end
   end
   assign Timeout_Err = terr_q;
`else
   assign Timeout_Err = 1'b0;
`endif

   assign Tx_Data        = data_q;
   assign Transmit_Start = start_q;
   assign Gnt            = gnt_q;
   assign Done           = done_q;
   assign Active         = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference plus directed checks.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ       = 4;
   localparam int DATA_BITS     = 8;
   localparam int START_TIMEOUT = 64;
`ifdef UART_ARB_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam logic [NUM_REQ*DATA_BITS-1:0] INIT_DATA = {8'h3C, 8'h77, 8'h12, 8'hA5};

   logic                         clk;
   logic                         rst_n;
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*DATA_BITS-1:0] req_data;
   logic                         cts;
   logic                         tx_busy;
   logic [DATA_BITS-1:0]         tx_data;
   logic                         transmit_start;
   logic [NUM_REQ-1:0]           gnt;
   logic [NUM_REQ-1:0]           done;
   logic                         active;
   logic                         timeout_err;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int gnt_log[$];
   bit outstanding = 1'b0;

   // Reference: who owns the channel, whether the transmitter answered, what each output must be
   bit             m_own, m_answered, m_ts, m_terr;
   int             m_owner, m_ptr, m_gnt, m_done, m_ts_cycles;
   logic [DATA_BITS-1:0] m_data;

   uart_tx_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .DATA_BITS     (DATA_BITS),
      .START_TIMEOUT (START_TIMEOUT)
   ) dut (
      .Clk            (clk),
      .Rst_n          (rst_n),
      .Req            (req),
      .Req_Data       (req_data),
      .CTS            (cts),
      .Tx_Busy        (tx_busy),
      .Tx_Data        (tx_data),
      .Transmit_Start (transmit_start),
      .Gnt            (gnt),
      .Done           (done),
      .Active         (active),
      .Timeout_Err    (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_own = 0; m_answered = 0; m_ts = 0; m_terr = 0;
      m_owner = 0; m_ptr = 0; m_gnt = -1; m_done = -1; m_ts_cycles = 0;
      m_data = '0;
   endtask

   task automatic model_edge();
      int w;
      m_gnt = -1; m_done = -1; m_terr = 0;
      if (!m_own) begin
         if (cts && !tx_busy && req != 0) begin
            w = -1;
            for (int k = 0; k < NUM_REQ; k++)
               if (w < 0 && req[(m_ptr + k) % NUM_REQ]) w = (m_ptr + k) % NUM_REQ;
            m_data      = DATA_BITS'(req_data >> (w * DATA_BITS));
            m_owner     = w;
            m_gnt       = w;
            m_ptr       = (w + 1) % NUM_REQ;
            m_own       = 1;
            m_answered  = 0;
            m_ts        = 0;
            m_ts_cycles = 0;
         end
      end else if (!m_answered) begin
         if (tx_busy) begin
            m_answered = 1;
            m_ts = 0;
         end else begin
            if (m_ts) m_ts_cycles++;
            if (TMO_EN && m_ts_cycles >= START_TIMEOUT) begin
               m_terr = 1; m_ts = 0; m_own = 0;
            end else begin
               m_ts = 1;
            end
         end
      end else if (!tx_busy) begin
         m_done = m_owner;
         m_own  = 0;
      end
   endtask

   // Advance the reference every edge and compare all outputs shortly after
   always @(posedge clk) begin
      int gi;
      if (!rst_n) model_reset();
      else        model_edge();
      cyc++;
      #1;
      chk("tx_data",        64'(tx_data),        64'(m_data));
      chk("transmit_start", 64'(transmit_start), 64'(m_ts));
      chk("gnt",            64'(gnt),            (m_gnt  >= 0) ? 64'(1) << m_gnt  : 64'(0));
      chk("done",           64'(done),           (m_done >= 0) ? 64'(1) << m_done : 64'(0));
      chk("active",         64'(active),         64'(m_own));
      chk("timeout_err",    64'(timeout_err),    64'(m_terr));
      if (gnt != 0) begin
         chk("gnt_onehot", 64'($onehot(gnt)), 64'(1));
         chk("gnt_without_done", 64'(outstanding), 64'(0));
         outstanding = 1'b1;
         gi = 0;
         for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) gi = i;
         gnt_log.push_back(gi);
      end
      if (done != 0 || timeout_err || !rst_n) outstanding = 1'b0;
   end

   // Wait for the start strobe, then emulate the transmitter's busy window
   task automatic run_frame(input int dly, input int len);
      int n = 0;
      while (!transmit_start && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("frame_start_seen", 64'(transmit_start), 64'(1));
      repeat (dly) @(negedge clk);
      tx_busy = 1'b1;
      repeat (len) @(negedge clk);
      tx_busy = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int ts_cnt, n, t0, t1;
      rst_n = 1'b0; req = '0; req_data = INIT_DATA; cts = 1'b1; tx_busy = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_tx_data", 64'(tx_data), 64'(0));
      chk("rst_transmit_start", 64'(transmit_start), 64'(0));
      chk("rst_gnt", 64'(gnt), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_active", 64'(active), 64'(0));
      chk("rst_timeout_err", 64'(timeout_err), 64'(0));
      rst_n = 1'b1;

      // single client, transmitter answers 3 cycles after start
      @(negedge clk); req = 4'b0001;
      @(negedge clk);
      chk("t1_gnt", 64'(gnt), 64'h1);
      chk("t1_tx_data", 64'(tx_data), 64'hA5);
      chk("t1_start_low_at_gnt", 64'(transmit_start), 64'(0));
      req = '0;
      req_data[7:0] = 8'hFF;
      ts_cnt = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (transmit_start) ts_cnt++;
         if (k == 2) tx_busy = 1'b1;
      end
      chk("t1_start_cycles", 64'(ts_cnt), 64'd3);
      chk("t1_active_busy", 64'(active), 64'(1));
      tx_busy = 1'b0;
      @(negedge clk);
      chk("t1_done", 64'(done), 64'h1);
      chk("t1_data_held", 64'(tx_data), 64'hA5);
      req_data = INIT_DATA;

      // all clients requesting: rotation 0,1,2,3,0
      do_reset();
      gnt_log.delete();
      req = 4'b1111;
      repeat (5) run_frame(1, 4);
      @(negedge clk); req = '0;
      repeat (3) @(negedge clk);
      chk("t2_grant_count", 64'(gnt_log.size()), 64'd5);
      for (int i = 0; i < 5; i++)
         if (i < gnt_log.size()) chk("t2_grant_order", 64'(gnt_log[i]), 64'(exp_order[i]));

      // CTS low blocks starts; grant one cycle after CTS returns
      gnt_log.delete();
      cts = 1'b0; req = 4'b0100;
      repeat (20) @(negedge clk);
      chk("t3_no_gnt_cts_low", 64'(gnt_log.size()), 64'd0);
      cts = 1'b1;
      @(negedge clk);
      chk("t3_gnt", 64'(gnt), 64'h4);
      chk("t3_tx_data", 64'(tx_data), 64'h77);
      req = '0;
      run_frame(0, 2);
      repeat (3) @(negedge clk);

      // request withdrawn while another client owns the channel
      gnt_log.delete();
      req = 4'b0001;
      @(negedge clk); req = '0;
      n = 0;
      while (!transmit_start && n < 50) begin @(negedge clk); n++; end
      tx_busy = 1'b1;
      @(negedge clk); req = 4'b0010;
      repeat (3) @(negedge clk);
      req = '0;
      @(negedge clk); tx_busy = 1'b0;
      repeat (5) @(negedge clk);
      chk("t6_grant_count", 64'(gnt_log.size()), 64'd1);
      if (gnt_log.size() > 0) chk("t6_only_owner", 64'(gnt_log[0]), 64'd0);

      // transmitter never answers
      gnt_log.delete();
      req = 4'b0001;
      @(negedge clk); req = '0;
      n = 0;
      while (!transmit_start && n < 50) begin @(negedge clk); n++; end
      t0 = cyc;
`ifdef UART_ARB_TIMEOUT_EN
      n = 0;
      while (!timeout_err && n < 100) begin @(negedge clk); n++; end
      t1 = cyc;
      chk("t4_timeout_delay", 64'(t1 - t0), 64'd64);
      @(negedge clk);
      chk("t4_released", 64'(active), 64'(0));
`else
      repeat (80) @(negedge clk);
      t1 = cyc;
      chk("t4_still_waiting_cycles", 64'(t1 - t0), 64'd80);
      chk("t4_still_active", 64'(active), 64'(1));
      chk("t4_still_starting", 64'(transmit_start), 64'(1));
      chk("t4_no_timeout", 64'(timeout_err), 64'(0));
      run_frame(0, 2);
      repeat (2) @(negedge clk);
`endif

      // reset while busy, then pointer restarts at 0
      req = 4'b0010;
      @(negedge clk); req = '0;
      n = 0;
      while (!transmit_start && n < 50) begin @(negedge clk); n++; end
      tx_busy = 1'b1;
      repeat (2) @(negedge clk);
      chk("t5_active_before_reset", 64'(active), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("t5_rst_transmit_start", 64'(transmit_start), 64'(0));
      chk("t5_rst_active", 64'(active), 64'(0));
      chk("t5_rst_tx_data", 64'(tx_data), 64'(0));
      chk("t5_rst_gnt", 64'(gnt), 64'(0));
      chk("t5_rst_done", 64'(done), 64'(0));
      tx_busy = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1; req = 4'b1000;
      @(negedge clk);
      chk("t5_gnt_after_reset", 64'(gnt), 64'h8);
      chk("t5_tx_data", 64'(tx_data), 64'h3C);
      req = '0;
      run_frame(0, 2);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
